fpa_nbit: RTL and testbench



---
 rtl/fpa_nbit.sv | 35 +++
 tb/tb_fpa_nbit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fpa_nbit.sv
// fpa_nbit: N-bit fixed-priority arbiter with a registered one-hot grant.
// Each rising clock edge grants the lowest-indexed active requester.
// Bit 0 has the highest priority. The arbiter keeps no history, so it
// applies no fairness, rotation, locking or handshake.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-high reset; clears o_grant immediately
//   i_request  N-bit request vector; bit k high = requester k wants the resource
//   o_grant    N-bit registered grant; one-hot or all-zero
module fpa_nbit #(
  parameter int unsigned N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_request,
  output logic [N-1:0] o_grant
);

  logic [N-1:0] grant_c;

  // Isolate the lowest set bit. The subtraction wraps modulo 2^N, so an
  // all-zero request gives an all-zero grant. This also holds for N=1.
  assign grant_c = i_request & ~(i_request - N'(1));

  // Grant register. The previous grant is not fed back into the decision.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_grant <= '0;
    end else begin
      o_grant <= grant_c;
    end
  end

endmodule

// File: tb/tb_fpa_nbit.sv
// tb_fpa_nbit: scoreboard bench for fpa_nbit.
// Three instances share one clock and reset: N=8 (main), N=5 and N=1.
// Stimulus changes on the falling edge. Each change pushes the grant the
// reference model expects. A monitor pops that value after the next rising
// edge and compares it with the DUT output.
module tb_fpa_nbit;

  logic       clk;
  logic       rst;
  logic [7:0] req8;
  logic [4:0] req5;
  logic [0:0] req1;
  logic [7:0] grant8;
  logic [4:0] grant5;
  logic [0:0] grant1;

  int n_checks;
  int n_fail;

  logic [7:0] q8[$];
  logic [4:0] q5[$];
  logic [0:0] q1[$];

  fpa_nbit #(.N(8)) dut8 (.i_clk(clk), .i_rst(rst), .i_request(req8), .o_grant(grant8));
  fpa_nbit #(.N(5)) dut5 (.i_clk(clk), .i_rst(rst), .i_request(req5), .o_grant(grant5));
  fpa_nbit #(.N(1)) dut1 (.i_clk(clk), .i_rst(rst), .i_request(req1), .o_grant(grant1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scan upward and return the first requesting index as one-hot.
  function automatic logic [7:0] lowest_req(input logic [7:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      if (r[i]) return 8'(1) << i;
    end
    return 8'h00;
  endfunction

  function automatic bit is_onehot0(input logic [7:0] g);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 8; i++) cnt += int'(g[i]);
    return cnt <= 1;
  endfunction

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input bit cond);
    n_checks++;
    if (!cond) begin
      n_fail++;
      $display("FAIL %s: condition false at %0t (g8=%h g5=%h g1=%h)",
               name, $time, grant8, grant5, grant1);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and record the expected
  // grant for the rising edge that follows.
  task automatic drive(input logic [7:0] r8, input logic [4:0] r5, input logic r1,
                       input logic rst_v);
    @(negedge clk);
    rst  = rst_v;
    req8 = r8;
    req5 = r5;
    req1 = r1;
    q8.push_back(rst_v ? 8'h00 : lowest_req(r8, 8));
    q5.push_back(rst_v ? 5'h00 : 5'(lowest_req(8'(r5), 5)));
    q1.push_back(rst_v ? 1'b0 : 1'(lowest_req(8'(r1), 1)));
  endtask

  task automatic drive8(input logic [7:0] r8);
    drive(r8, 5'($urandom), 1'($urandom), 1'b0);
  endtask

  // Monitor: check one expected value per instance after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q8.size() > 0) check8("grant8", grant8, q8.pop_front());
    if (q5.size() > 0) check8("grant5", 8'(grant5), 8'(q5.pop_front()));
    if (q1.size() > 0) check8("grant1", 8'(grant1), 8'(q1.pop_front()));
    check_bit("onehot0", is_onehot0(grant8) && is_onehot0(8'(grant5)));
  end

  logic [7:0] r;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    req8 = 8'h00;
    req5 = 5'h00;
    req1 = 1'b0;
    #2;
    check8("reset_initial", grant8, 8'h00);

    // Hold reset with every request line active, then release it.
    drive(8'hFF, 5'h1F, 1'b1, 1'b1);
    drive(8'hFF, 5'h1F, 1'b1, 1'b1);
    drive(8'hFF, 5'h1F, 1'b1, 1'b0);

    // Single requests on successive cycles.
    for (int i = 0; i < 8; i++) drive8(8'(1) << i);

    // Multiple simultaneous requests.
    drive8(8'b1101_0100);
    drive8(8'b1000_0000);
    drive8(8'hFF);
    drive8(8'b1110_0000);

    // Idle, then preemption by a lower index.
    drive8(8'h00);
    drive8(8'h80);
    drive8(8'h80);
    drive8(8'h80);
    drive8(8'h82);
    drive8(8'h80);

    // Pulse the reset between edges while the 8'h10 grant is active.
    drive8(8'h10);
    drive8(8'h10);
    #2;
    rst = 1'b1;
    #1;
    check8("async_reset8", grant8, 8'h00);
    check8("async_reset5", 8'(grant5), 8'h00);
    check8("async_reset1", 8'(grant1), 8'h00);
    #1;
    rst = 1'b0;
    drive8(8'h30);

    // Random requests. Half of the cycles AND two draws together to get sparse vectors.
    for (int i = 0; i < 1000; i++) begin
      r = 8'($urandom);
      if (i % 2 == 0) r = r & 8'($urandom);
      drive(r, 5'($urandom), 1'($urandom), 1'b0);
    end

    // Let the monitor consume the last expected values.
    @(posedge clk);
    #3;
    check_bit("scoreboard_drained", q8.size() == 0 && q5.size() == 0 && q1.size() == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
